// File: rtl/matrix_multi_pkg.sv
// Shared widths, lane types and the 37->32 bit reduction for the matrix_multi MAC slice.
// Optional feature macro: MATRIX_MULTI_SAT_EN (saturate instead of wrap).
package matrix_multi_pkg;

  localparam int N_LANES    = 16;
  localparam int DATA_W     = 16;
  localparam int ACC_W      = 32;
  localparam int SUM_FULL_W = 37;

  typedef logic signed [DATA_W-1:0]     elem_t;
  typedef logic signed [ACC_W-1:0]      acc_t;
  typedef logic signed [SUM_FULL_W-1:0] acc_full_t;

  function automatic acc_t reduce_sum(input acc_full_t full);
    acc_t res;
`ifdef MATRIX_MULTI_SAT_EN
    // Out of range exactly when the bits above the 32-bit sign bit disagree with it.
    if (full > acc_full_t'(acc_t'(32'h7FFF_FFFF)))
      res = acc_t'(32'h7FFF_FFFF);
    else if (full < acc_full_t'(acc_t'(32'h8000_0000)))
      res = acc_t'(32'h8000_0000);
    else
      res = acc_t'(full);
`else
    res = acc_t'(full);
`endif
    return res;
  endfunction

endpackage

// File: rtl/matrix_multi_mac_lane.sv
// One output lane: 16 signed products plus the incoming partial sum, summed at full precision.
module mac_lane
  import matrix_multi_pkg::*;
(
  input  logic [N_LANES*DATA_W-1:0] data_vec,
  input  logic [N_LANES*DATA_W-1:0] weight_vec,
  input  acc_t                      sum_in,
  output acc_full_t                 sum_full
);

  acc_full_t lvl0 [N_LANES];
  acc_full_t lvl1 [N_LANES/2];
  acc_full_t lvl2 [N_LANES/4];
  acc_full_t lvl3 [N_LANES/8];

  genvar gi;
  generate
    for (gi = 0; gi < N_LANES; gi++) begin : g_prod
      elem_t d_e;
      elem_t w_e;
      acc_t  prod;
      assign d_e  = elem_t'(data_vec[gi*DATA_W +: DATA_W]);
      assign w_e  = elem_t'(weight_vec[gi*DATA_W +: DATA_W]);
      // 16x16 signed never exceeds 2^30 in magnitude, so 32 bits is exact.
      assign prod = acc_t'(d_e) * acc_t'(w_e);
      assign lvl0[gi] = acc_full_t'(prod);
    end

    for (gi = 0; gi < N_LANES/2; gi++) begin : g_l1
      assign lvl1[gi] = lvl0[2*gi] + lvl0[2*gi+1];
    end

    for (gi = 0; gi < N_LANES/4; gi++) begin : g_l2
      assign lvl2[gi] = lvl1[2*gi] + lvl1[2*gi+1];
    end

    for (gi = 0; gi < N_LANES/8; gi++) begin : g_l3
      assign lvl3[gi] = lvl2[2*gi] + lvl2[2*gi+1];
    end
  endgenerate

  assign sum_full = lvl3[0] + lvl3[1] + acc_full_t'(sum_in);

endmodule

// File: rtl/matrix_multi.sv
// 16x16 signed multiply-accumulate slice with a registered 16-lane result and one-cycle latency.
// Build option: define MATRIX_MULTI_SAT_EN to saturate lanes instead of wrapping.
module matrix_multi
  import matrix_multi_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic [N_LANES*DATA_W-1:0] data_buffer,
  input  logic [N_LANES*DATA_W-1:0] weight_buffer1,
  input  logic [N_LANES*DATA_W-1:0] weight_buffer2,
  input  logic [N_LANES*DATA_W-1:0] weight_buffer3,
  input  logic [N_LANES*DATA_W-1:0] weight_buffer4,
  input  logic [N_LANES*DATA_W-1:0] weight_buffer5,
  input  logic [N_LANES*DATA_W-1:0] weight_buffer6,
  input  logic [N_LANES*DATA_W-1:0] weight_buffer7,
  input  logic [N_LANES*DATA_W-1:0] weight_buffer8,
  input  logic [N_LANES*DATA_W-1:0] weight_buffer9,
  input  logic [N_LANES*DATA_W-1:0] weight_buffer10,
  input  logic [N_LANES*DATA_W-1:0] weight_buffer11,
  input  logic [N_LANES*DATA_W-1:0] weight_buffer12,
  input  logic [N_LANES*DATA_W-1:0] weight_buffer13,
  input  logic [N_LANES*DATA_W-1:0] weight_buffer14,
  input  logic [N_LANES*DATA_W-1:0] weight_buffer15,
  input  logic [N_LANES*DATA_W-1:0] weight_buffer16,
  input  logic [N_LANES*ACC_W-1:0]  sum_input,
  output logic [N_LANES*ACC_W-1:0]  sum_output,
  output logic                      out_valid
);

  // Row k holds the weights of input element k for every output lane.
  logic [N_LANES*DATA_W-1:0] w_rows [N_LANES];

  assign w_rows[0]  = weight_buffer1;
  assign w_rows[1]  = weight_buffer2;
  assign w_rows[2]  = weight_buffer3;
  assign w_rows[3]  = weight_buffer4;
  assign w_rows[4]  = weight_buffer5;
  assign w_rows[5]  = weight_buffer6;
  assign w_rows[6]  = weight_buffer7;
  assign w_rows[7]  = weight_buffer8;
  assign w_rows[8]  = weight_buffer9;
  assign w_rows[9]  = weight_buffer10;
  assign w_rows[10] = weight_buffer11;
  assign w_rows[11] = weight_buffer12;
  assign w_rows[12] = weight_buffer13;
  assign w_rows[13] = weight_buffer14;
  assign w_rows[14] = weight_buffer15;
  assign w_rows[15] = weight_buffer16;

  logic [N_LANES*ACC_W-1:0] sum_next;
  logic [N_LANES*ACC_W-1:0] sum_reg;
  logic                     valid_reg;

  genvar gi, gj;
  generate
    for (gi = 0; gi < N_LANES; gi++) begin : g_lane
      logic [N_LANES*DATA_W-1:0] lane_w;
      acc_full_t                 lane_full;

      // Transpose: gather column gi of the weight tile into one vector.
      for (gj = 0; gj < N_LANES; gj++) begin : g_col
        assign lane_w[gj*DATA_W +: DATA_W] = w_rows[gj][gi*DATA_W +: DATA_W];
      end

      mac_lane u_mac_lane (
        .data_vec   (data_buffer),
        .weight_vec (lane_w),
        .sum_in     (acc_t'(sum_input[gi*ACC_W +: ACC_W])),
        .sum_full   (lane_full)
      );

      assign sum_next[gi*ACC_W +: ACC_W] = reduce_sum(lane_full);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_reg   <= '0;
      valid_reg <= 1'b0;
    end else begin
      valid_reg <= in_valid;
      if (in_valid)
        sum_reg <= sum_next;
    end
  end

  assign sum_output = sum_reg;
  assign out_valid  = valid_reg;

endmodule

// File: tb/tb_matrix_multi.sv
// Directed + randomized bench for matrix_multi against an arithmetic lane model.
module tb_matrix_multi;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [255:0] data_buffer;
  logic [255:0] wb [16];
  logic [511:0] sum_input;
  logic [511:0] sum_output;
  logic         out_valid;

  int d [16];
  int w [16][16];
  int s [16];
  logic [511:0] expv;
  logic [511:0] hold_v;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  matrix_multi dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .data_buffer(data_buffer),
    .weight_buffer1(wb[0]),   .weight_buffer2(wb[1]),   .weight_buffer3(wb[2]),
    .weight_buffer4(wb[3]),   .weight_buffer5(wb[4]),   .weight_buffer6(wb[5]),
    .weight_buffer7(wb[6]),   .weight_buffer8(wb[7]),   .weight_buffer9(wb[8]),
    .weight_buffer10(wb[9]),  .weight_buffer11(wb[10]), .weight_buffer12(wb[11]),
    .weight_buffer13(wb[12]), .weight_buffer14(wb[13]), .weight_buffer15(wb[14]),
    .weight_buffer16(wb[15]),
    .sum_input(sum_input), .sum_output(sum_output), .out_valid(out_valid)
  );

  function automatic int rnd16();
    logic [15:0] t;
    t = 16'($urandom);
    return int'($signed(t));
  endfunction

  function automatic logic [511:0] model_out();
    logic [511:0] r;
    longint acc;
    logic [31:0] lane;
    r = '0;
    for (int j = 0; j < 16; j++) begin
      acc = longint'(s[j]);
      for (int k = 0; k < 16; k++)
        acc += longint'(d[k]) * longint'(w[k][j]);
`ifdef MATRIX_MULTI_SAT_EN
      if (acc > 64'sd2147483647)       lane = 32'h7FFF_FFFF;
      else if (acc < -64'sd2147483648) lane = 32'h8000_0000;
      else                             lane = acc[31:0];
`else
      lane = acc[31:0];
`endif
      r[32*j +: 32] = lane;
    end
    return r;
  endfunction

  task automatic apply();
    for (int k = 0; k < 16; k++) begin
      data_buffer[16*k +: 16] = d[k][15:0];
      for (int j = 0; j < 16; j++)
        wb[k][16*j +: 16] = w[k][j][15:0];
    end
    for (int j = 0; j < 16; j++)
      sum_input[32*j +: 32] = s[j];
  endtask

  task automatic fill(input int dv, input int wv, input int sv);
    for (int k = 0; k < 16; k++) begin
      d[k] = dv;
      s[k] = sv;
      for (int j = 0; j < 16; j++) w[k][j] = wv;
    end
  endtask

  task automatic randomize_ops();
    for (int k = 0; k < 16; k++) begin
      d[k] = rnd16();
      s[k] = int'($urandom);
      for (int j = 0; j < 16; j++) w[k][j] = rnd16();
    end
  endtask

  task automatic chk_vec(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Present current operands for one edge; keep in_valid high when keep=1.
  task automatic beat(input string tag, input bit keep);
    apply();
    in_valid = 1'b1;
    expv = model_out();
    @(posedge clk); #1;
    if (!keep) in_valid = 1'b0;
    chk_vec({tag, "_sum"}, sum_output, expv);
    chk_bit({tag, "_valid"}, out_valid, 1'b1);
    $display("beat %s sum_lane0=%h", tag, sum_output[31:0]);
  endtask

  initial begin
    // Reset wins over a concurrent beat
    rst = 1'b1;
    in_valid = 1'b1;
    randomize_ops();
    apply();
    @(posedge clk); #1;
    chk_vec("rst_sum", sum_output, '0);
    chk_bit("rst_valid", out_valid, 1'b0);
    rst = 1'b0;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_vec("idle_sum", sum_output, '0);
    chk_bit("idle_valid", out_valid, 1'b0);

    // Identity tile
    fill(0, 0, 0);
    for (int k = 0; k < 16; k++) begin
      d[k] = k + 1;
      w[k][k] = 1;
    end
    beat("identity", 1'b0);
    for (int j = 0; j < 16; j++) expv[32*j +: 32] = 32'(j + 1);
    chk_vec("identity_const", sum_output, expv);
    @(posedge clk); #1;
    chk_bit("identity_one_cycle", out_valid, 1'b0);
    chk_vec("identity_hold", sum_output, expv);

    // Signed accumulate
    fill(-2, 3, 0);
    for (int j = 0; j < 16; j++) s[j] = 100 * j;
    beat("signed", 1'b0);
    for (int j = 0; j < 16; j++) expv[32*j +: 32] = 32'(100 * j - 96);
    chk_vec("signed_const", sum_output, expv);

    // Back-to-back random beats
    for (int b = 0; b < 6; b++) begin
      randomize_ops();
      beat($sformatf("rand%0d", b), b != 5);
    end

    // 49-beat chain with feedback from sum_output
    fill(1, 1, 0);
    for (int n = 1; n <= 49; n++) begin
      beat($sformatf("chain%0d", n), n != 49);
      for (int j = 0; j < 16; j++) begin
        expv[32*j +: 32] = 32'(16 * n);
        s[j] = int'(sum_output[32*j +: 32]);
      end
      if (n == 1 || n == 25 || n == 49)
        chk_vec($sformatf("chain_count%0d", n), sum_output, expv);
    end
    for (int j = 0; j < 16; j++) expv[32*j +: 32] = 32'd784;
    chk_vec("chain_784", sum_output, expv);

    // Overflow boundary
    fill(32'sh7FFF, 32'sh7FFF, 32'sh7FFF_FFFF);
    beat("overflow", 1'b0);
`ifdef MATRIX_MULTI_SAT_EN
    for (int j = 0; j < 16; j++) expv[32*j +: 32] = 32'h7FFF_FFFF;
`else
    for (int j = 0; j < 16; j++) expv[32*j +: 32] = 32'h7FF0_000F;
`endif
    chk_vec("overflow_const", sum_output, expv);

    // Hold while idle with changing inputs
    hold_v = sum_output;
    hold_v = expv;
    for (int c = 0; c < 5; c++) begin
      randomize_ops();
      apply();
      @(posedge clk); #1;
      chk_vec($sformatf("hold%0d_sum", c), sum_output, hold_v);
      chk_bit($sformatf("hold%0d_valid", c), out_valid, 1'b0);
      $display("idle %0d sum_lane0=%h", c, sum_output[31:0]);
    end

    // Mid-chain reset, then restart from zero
    fill(1, 1, 0);
    for (int n = 1; n <= 3; n++) begin
      beat($sformatf("pre_rst%0d", n), 1'b1);
      for (int j = 0; j < 16; j++) s[j] = int'(sum_output[32*j +: 32]);
    end
    apply();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    in_valid = 1'b0;
    chk_vec("midrst_sum", sum_output, '0);
    chk_bit("midrst_valid", out_valid, 1'b0);
    fill(1, 1, 0);
    beat("restart", 1'b0);
    for (int j = 0; j < 16; j++) expv[32*j +: 32] = 32'd16;
    chk_vec("restart_const", sum_output, expv);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
